uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer among
// N_CLIENTS valid/ready byte streams.
// Optional feature: define UART_ARB_LOCK_EN to compile in packet locking, which
// keeps a multi-byte packet (terminated by i_last) contiguous on the line.
module uart_tx_arbiter #(
  parameter int unsigned N_CLIENTS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_CLIENTS-1:0]   i_valid,
  input  logic [8*N_CLIENTS-1:0] i_data,
  input  logic [N_CLIENTS-1:0]   i_last,
  output logic [N_CLIENTS-1:0]   o_ready,
  output logic [N_CLIENTS-1:0]   o_grant,
  output logic                   o_write,
  output logic [7:0]             o_data,
  input  logic                   i_busy,
  output logic                   o_active
);

  localparam int unsigned PtrW = $clog2(N_CLIENTS);
  localparam logic [N_CLIENTS-1:0] OneHot0 = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StIssue, StDrain} state_e;

  state_e               r_state;
  logic [PtrW-1:0]      r_rr_ptr;
  logic [PtrW-1:0]      r_owner;
  logic [N_CLIENTS-1:0] r_grant;
  logic [N_CLIENTS-1:0] r_ready;
  logic                 r_write;
  logic [7:0]           r_data;

  logic [N_CLIENTS-1:0] w_elig;
  logic                 w_found;
  logic [PtrW-1:0]      w_win;
  logic [31:0]          w_cand;
  logic [N_CLIENTS-1:0] w_win_oh;
  logic [7:0]           w_byte;
  logic [PtrW-1:0]      w_ptr_next;

`ifdef UART_ARB_LOCK_EN
  logic r_locked;
  logic r_last;
  logic w_last;

  // While a packet is in flight only its owner may win.
  assign w_elig   = r_locked ? (i_valid & r_grant) : i_valid;
  assign o_active = (r_state != StIdle) || r_locked;
`else
  logic w_unused_last;

  assign w_elig        = i_valid;
  assign w_unused_last = ^i_last;
  assign o_active      = (r_state != StIdle);
`endif

  // Round-robin search: first eligible client at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      w_cand = 32'(r_rr_ptr) + i;
      if (w_cand >= N_CLIENTS) w_cand = w_cand - N_CLIENTS;
      if (!w_found && w_elig[w_cand[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PtrW-1:0];
      end
    end
  end

  // Select the owner's byte (and end-of-packet flag) for the LOAD capture.
  always_comb begin
    w_byte = '0;
`ifdef UART_ARB_LOCK_EN
    w_last = 1'b0;
`endif
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (r_owner == PtrW'(k)) begin
        w_byte = i_data[8*k +: 8];
`ifdef UART_ARB_LOCK_EN
        w_last = i_last[k];
`endif
      end
    end
  end

  assign w_win_oh   = OneHot0 << w_win;
  // Explicit wrap so non-power-of-two client counts work.
  assign w_ptr_next = (r_owner == PtrW'(N_CLIENTS - 1)) ? '0 : r_owner + 1'b1;

  // Arbitration FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_ready  <= '0;
      r_write  <= 1'b0;
      r_data   <= '0;
`ifdef UART_ARB_LOCK_EN
      r_locked <= 1'b0;
      r_last   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          // The busy gate also covers a serializer still finishing after reset.
          if (!i_busy && w_found) begin
            r_grant <= w_win_oh;
            r_ready <= w_win_oh;
            r_owner <= w_win;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_ready <= '0;
          r_data  <= w_byte;
`ifdef UART_ARB_LOCK_EN
          r_last  <= w_last;
`endif
          r_write <= 1'b1;
          r_state <= StIssue;
        end
        StIssue: begin
          // uart_tx only samples on its baud tick; hold until it reports busy.
          if (i_busy) begin
            r_write <= 1'b0;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (!i_busy) begin
            r_data  <= '0;
            r_state <= StIdle;
`ifdef UART_ARB_LOCK_EN
            if (!r_last) begin
              r_locked <= 1'b1;
            end else begin
              r_locked <= 1'b0;
              r_rr_ptr <= w_ptr_next;
              r_grant  <= '0;
            end
`else
            r_rr_ptr <= w_ptr_next;
            r_grant  <= '0;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_grant = r_grant;
  assign o_write = r_write;
  assign o_data  = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model.
// Build with UART_ARB_LOCK_EN defined to exercise the packet-lock case instead
// of the per-byte alternation case.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [3:0]  last = '0;
  logic [31:0] data = '0;
  logic [3:0]  ready;
  logic [3:0]  grant;
  logic        write;
  logic [7:0]  odata;
  logic        busy;
  logic        active;

  // Busy model controls (written only by the stimulus process).
  logic model_en = 1'b0;
  logic man_busy = 1'b0;
  int   busy_delay = 2;
  int   busy_hold = 3;

  // Busy model state (written only by the model process).
  logic       mb = 1'b0;
  logic       ph = 1'b0;
  int         wc = 0;
  int         hc = 0;
  logic [7:0] cap [64];
  int         cap_n = 0;

  // Client stimulus and observation logs.
  logic [7:0] c_byte [4][8];
  logic       c_last [4][8];
  int         c_n [4];
  int         c_h [4];
  logic [3:0] rdy_prev = '0;
  int         g_log [64];
  int         g_n = 0;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign busy = model_en ? mb : man_busy;

  uart_tx_arbiter #(.N_CLIENTS(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (data),
    .i_last  (last),
    .o_ready (ready),
    .o_grant (grant),
    .o_write (write),
    .o_data  (odata),
    .i_busy  (busy),
    .o_active(active)
  );

  // Serializer model: raises busy busy_delay edges after o_write, capturing the byte.
  always @(posedge clk) begin
    if (!model_en) begin
      mb <= 1'b0; ph <= 1'b0; wc <= 0; hc <= 0;
    end else if (!ph) begin
      if (write) begin
        if (wc == busy_delay - 1) begin
          mb <= 1'b1; ph <= 1'b1; wc <= 0; hc <= 0;
          cap[cap_n & 63] <= odata;
          cap_n <= cap_n + 1;
        end else begin
          wc <= wc + 1;
        end
      end else begin
        wc <= 0;
      end
    end else begin
      if (hc == busy_hold - 1) begin
        mb <= 1'b0; ph <= 1'b0;
      end else begin
        hc <= hc + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (c_h[k] < c_n[k]) begin
        valid[k]        = 1'b1;
        data[8*k +: 8]  = c_byte[k][c_h[k]];
        last[k]         = c_last[k][c_h[k]];
      end else begin
        valid[k]        = 1'b0;
        data[8*k +: 8]  = 8'h00;
        last[k]         = 1'b0;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic l);
    if (c_n[k] < 8) begin
      c_byte[k][c_n[k]] = b;
      c_last[k][c_n[k]] = l;
      c_n[k]++;
    end
    drive();
  endtask

  // One clock: sample #1 after the edge, log ready pulses, advance clients
  // one cycle after their ready so the byte stays stable through LOAD.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (rdy_prev[k] && c_h[k] < c_n[k]) c_h[k]++;
    end
    if (ready != 4'b0000 && g_n < 64) begin
      for (int k = 0; k < 4; k++) if (ready[k]) g_log[g_n] = k;
      g_n++;
    end
    rdy_prev = ready;
    drive();
  endtask

  task automatic clear_clients();
    for (int k = 0; k < 4; k++) begin
      c_n[k] = 0;
      c_h[k] = 0;
    end
    rdy_prev = '0;
    drive();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    model_en = 1'b0;
    man_busy = 1'b0;
    clear_clients();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : stim
    int g0;
    int c0;
    int n;
    int bad;
    int bad_r;
    int lat;
    int exp_g [6];
    logic [7:0] exp_b [6];

    for (int k = 0; k < 4; k++) begin
      c_n[k] = 0;
      c_h[k] = 0;
    end

    // Reset values.
    rst_n = 1'b0;
    tick();
    check("rst_outputs", {14'd0, ready, grant, write, odata, active}, 32'd0);

    // Single byte.
    do_reset();
    model_en = 1'b1; busy_delay = 5; busy_hold = 100;
    c0 = cap_n;
    push(0, 8'h48, 1'b1);
    tick();
    check("sb_ready", {28'd0, ready}, 32'h1);
    check("sb_grant", {28'd0, grant}, 32'h1);
    check("sb_write_in_load", {31'd0, write}, 32'd0);
    tick();
    check("sb_ready_one_cycle", {28'd0, ready}, 32'd0);
    check("sb_write", {31'd0, write}, 32'd1);
    check("sb_data", {24'd0, odata}, 32'h48);
    n = 0; bad = 0;
    while (write && n < 50) begin
      if (odata != 8'h48) bad++;
      n++;
      tick();
    end
    // ISSUE lasts from the write edge until the edge after busy rises (5 + 1 cycles).
    check("sb_write_len", n, 6);
    check("sb_data_stable", bad, 0);
    check("sb_drain_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 200 && busy; i++) tick();
    check("sb_busy_fell", {31'd0, busy}, 32'd0);
    check("sb_still_drain", {31'd0, active}, 32'd1);
    check("sb_drain_data", {24'd0, odata}, 32'h48);
    tick();
    check("sb_idle", {31'd0, active}, 32'd0);
    check("sb_grant_clr", {28'd0, grant}, 32'd0);
    check("sb_data_clr", {24'd0, odata}, 32'd0);
    check("sb_wire", {24'd0, cap[c0 & 63]}, 32'h48);

    // Fairness: everyone valid, every byte ends its packet.
    do_reset();
    model_en = 1'b1; busy_delay = 2; busy_hold = 3;
    g0 = g_n; c0 = cap_n;
    for (int k = 0; k < 4; k++) begin
      push(k, 8'h10 + 8'(k), 1'b1);
      push(k, 8'h20 + 8'(k), 1'b1);
    end
    for (int i = 0; i < 600 && (g_n < g0 + 6 || cap_n < c0 + 6); i++) tick();
    exp_g = '{0, 1, 2, 3, 0, 1};
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21};
    for (int i = 0; i < 6; i++) begin
      check("rr_grant_order", g_log[(g0 + i) & 63], exp_g[i]);
      check("rr_wire_order", {24'd0, cap[(c0 + i) & 63]}, {24'd0, exp_b[i]});
    end

`ifdef UART_ARB_LOCK_EN
    // Packet lock: client 2 owns the line for A,B,C despite client 1 waiting.
    do_reset();
    model_en = 1'b1; busy_delay = 2; busy_hold = 3;
    g0 = g_n; c0 = cap_n;
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    for (int i = 0; i < 20 && g_n == g0; i++) tick();
    check("lk_first_grant", {28'd0, grant}, 32'h4);
    push(1, 8'h31, 1'b1);
    bad = 0;
    for (int i = 0; i < 600 && (g_n < g0 + 4 || cap_n < c0 + 4); i++) begin
      tick();
      if (g_n - g0 < 3 && (grant != 4'b0100 || !active)) bad++;
    end
    check("lk_grant_held", bad, 0);
    exp_g[0:3] = '{2, 2, 2, 1};
    exp_b[0:3] = '{8'h41, 8'h42, 8'h43, 8'h31};
    for (int i = 0; i < 4; i++) begin
      check("lk_grant_order", g_log[(g0 + i) & 63], exp_g[i]);
      check("lk_wire_order", {24'd0, cap[(c0 + i) & 63]}, {24'd0, exp_b[i]});
    end
`else
    // No lock: i_last=0 is ignored, arbitration is per byte.
    do_reset();
    model_en = 1'b1; busy_delay = 2; busy_hold = 3;
    g0 = g_n;
    push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0);
    push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b0);
    for (int i = 0; i < 600 && g_n < g0 + 4; i++) tick();
    exp_g[0:3] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) check("nl_grant_order", g_log[(g0 + i) & 63], exp_g[i]);
`endif

    // Slow accept: serializer ignores o_write for a long time.
    do_reset();
    model_en = 1'b1; busy_delay = 21; busy_hold = 3;
    g0 = g_n; c0 = cap_n;
    push(0, 8'h5a, 1'b1);
    push(1, 8'h66, 1'b1);
    for (int i = 0; i < 20 && !write; i++) tick();
    check("sa_write_seen", {31'd0, write}, 32'd1);
    bad = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      if (!write || odata != 8'h5a) bad++;
      if (ready != 4'b0000) bad_r++;
      tick();
    end
    check("sa_write_stable", bad, 0);
    check("sa_no_ready", bad_r, 0);
    for (int i = 0; i < 600 && (g_n < g0 + 2 || cap_n < c0 + 2); i++) tick();
    check("sa_second_grant", g_log[(g0 + 1) & 63], 1);
    check("sa_wire0", {24'd0, cap[c0 & 63]}, 32'h5a);
    check("sa_wire1", {24'd0, cap[(c0 + 1) & 63]}, 32'h66);

    // Reset in DRAIN while the serializer is still busy.
    do_reset();
    model_en = 1'b1; busy_delay = 2; busy_hold = 30;
    push(0, 8'h77, 1'b1);
    for (int i = 0; i < 40 && !(busy && active && !write); i++) tick();
    check("rd_in_drain", {31'd0, busy && active && !write}, 32'd1);
    man_busy = 1'b1;
    model_en = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rd_outputs_in_reset", {14'd0, ready, grant, write, odata, active}, 32'd0);
    clear_clients();
    tick();
    rst_n = 1'b1;
    push(3, 8'h33, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready != 4'b0000 || grant != 4'b0000 || active) bad++;
    end
    check("rd_gated_by_busy", bad, 0);
    man_busy = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && ready == 4'b0000; i++) begin
      tick();
      lat++;
    end
    check("rd_first_ready", {28'd0, ready}, 32'h8);
    check("rd_first_grant", {28'd0, grant}, 32'h8);
    // IDLE arbitrates on the first edge that samples busy low.
    check("rd_grant_latency", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
